inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 27 ++
 rtl/inst_fetch.sv | 155 +++++++++++++++
 tb/tb_inst_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Instruction-fetch bus: program-memory read port, jump/halt control and
// the instruction hand-off toward the control unit.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [7:0]        mem_data;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_addr;
  logic              halt;
  logic [7:0]        inst;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] pc;

  modport master (
    output mem_addr, mem_req, inst, inst_valid, pc,
    input  mem_ack, mem_data, jmp, jmp_addr, halt, inst_ready
  );

  modport slave (
    input  mem_addr, mem_req, inst, inst_valid, pc,
    output mem_ack, mem_data, jmp, jmp_addr, halt, inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: walks the program counter, reads program memory and
// hands one byte at a time to the control unit. FETCH_PREFETCH_EN adds a
// one-entry prefetch buffer for single-cycle throughput.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  logic [1:0]        state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  entry_t            cur, cur_nxt;
  logic              valid, valid_nxt;
  logic              req, req_nxt;
  logic              ack;
  logic [ADDR_W-1:0] pc_inc;
  entry_t            fetched;
`ifdef FETCH_PREFETCH_EN
  entry_t            pf, pf_nxt;
  logic              pf_full, pf_full_nxt;
`endif

  // An ack only counts while a request is actually outstanding
  assign ack           = bus.mem_ack & req;
  assign pc_inc        = fetch_pc + ADDR_W'(1);
  assign fetched.data  = bus.mem_data;
  assign fetched.addr  = fetch_pc;

  // Next-state and datapath decisions
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    cur_nxt      = cur;
    valid_nxt    = valid;
`ifdef FETCH_PREFETCH_EN
    pf_nxt       = pf;
    pf_full_nxt  = pf_full;
`endif
    case (state)
      IDLE: begin
        if (bus.jmp) begin
          fetch_pc_nxt = bus.jmp_addr;
          state_nxt    = FETCH;
        end else begin
          state_nxt = bus.halt ? HALTED : FETCH;
        end
      end
      FETCH: begin
        if (bus.jmp) begin
          fetch_pc_nxt = bus.jmp_addr;
          valid_nxt    = 1'b0;
        end else if (ack) begin
          cur_nxt      = fetched;
          fetch_pc_nxt = pc_inc;
          valid_nxt    = 1'b1;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (bus.jmp) begin
          fetch_pc_nxt = bus.jmp_addr;
          valid_nxt    = 1'b0;
          state_nxt    = FETCH;
`ifdef FETCH_PREFETCH_EN
          pf_full_nxt  = 1'b0;
`endif
        end else begin
`ifdef FETCH_PREFETCH_EN
          if (bus.inst_ready) begin
            if (bus.halt) begin
              // Rewind over a prefetched byte so resume restarts in order
              valid_nxt   = 1'b0;
              state_nxt   = HALTED;
              pf_full_nxt = 1'b0;
              if (pf_full) fetch_pc_nxt = pf.addr;
            end else if (pf_full) begin
              cur_nxt     = pf;
              pf_full_nxt = 1'b0;
            end else if (ack) begin
              cur_nxt      = fetched;
              fetch_pc_nxt = pc_inc;
            end else begin
              valid_nxt = 1'b0;
              state_nxt = FETCH;
            end
          end else if (ack) begin
            pf_nxt       = fetched;
            pf_full_nxt  = 1'b1;
            fetch_pc_nxt = pc_inc;
          end
`else
          if (bus.inst_ready) begin
            valid_nxt = 1'b0;
            state_nxt = bus.halt ? HALTED : FETCH;
          end
`endif
        end
      end
      HALTED: begin
        if (bus.jmp) fetch_pc_nxt = bus.jmp_addr;
        if (!bus.halt) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase

    req_nxt = (state_nxt == FETCH);
`ifdef FETCH_PREFETCH_EN
    if ((state_nxt == HOLD) && !pf_full_nxt) req_nxt = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      cur      <= '{data: '0, addr: RESET_PC};
      valid    <= 1'b0;
      req      <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf       <= '0;
      pf_full  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      cur      <= cur_nxt;
      valid    <= valid_nxt;
      req      <= req_nxt;
`ifdef FETCH_PREFETCH_EN
      pf       <= pf_nxt;
      pf_full  <= pf_full_nxt;
`endif
    end
  end

  assign bus.mem_addr   = fetch_pc;
  assign bus.mem_req    = req;
  assign bus.inst       = cur.data;
  assign bus.pc         = cur.addr;
  assign bus.inst_valid = valid;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, checked
// against a program-order / handshake-rule reference model.
module tb_inst_fetch;
  logic clk = 1'b0;
  logic rst;
  logic ack_en;
  logic ack_force;
  logic [7:0] mem [256];

  int n_vec  = 0;
  int n_miss = 0;

  // Values observed just before an edge, and the expected next program address
  logic       pre_rst, pre_req, pre_ack, pre_jmp, pre_halt, pre_ready, pre_valid;
  logic [7:0] pre_addr, pre_data, pre_jaddr, pre_inst, pre_pc;
  logic [7:0] exp_pc;

  inst_fetch_if #(.ADDR_W(8)) bus ();

  inst_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Program memory: combinational read, ack gated by request unless forced
  always_comb begin
    bus.mem_ack  = ack_force | (ack_en & bus.mem_req);
    bus.mem_data = mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    if (pre_jmp) begin
      check("jmp_valid", 32'(bus.inst_valid), 32'(0));
      check("jmp_addr", 32'(bus.mem_addr), 32'(pre_jaddr));
      exp_pc = pre_jaddr;
    end else if (!pre_valid && pre_req) begin
      if (pre_ack) begin
        check("ack_valid", 32'(bus.inst_valid), 32'(1));
        check("ack_inst", 32'(bus.inst), 32'(pre_data));
        check("ack_pc", 32'(bus.pc), 32'(pre_addr));
        check("ack_next", 32'(bus.mem_addr), 32'(8'(pre_addr + 8'd1)));
      end else begin
        check("wait_req", 32'(bus.mem_req), 32'(1));
        check("wait_addr", 32'(bus.mem_addr), 32'(pre_addr));
        check("wait_valid", 32'(bus.inst_valid), 32'(0));
      end
    end else if (!pre_valid) begin
      check("idle_valid", 32'(bus.inst_valid), 32'(0));
      if (pre_halt) begin
        check("halt_req", 32'(bus.mem_req), 32'(0));
      end else begin
        check("resume_req", 32'(bus.mem_req), 32'(1));
        check("resume_addr", 32'(bus.mem_addr), 32'(pre_addr));
      end
    end else if (!pre_ready) begin
      check("hold_valid", 32'(bus.inst_valid), 32'(1));
      check("hold_inst", 32'(bus.inst), 32'(pre_inst));
      check("hold_pc", 32'(bus.pc), 32'(pre_pc));
    end else if (pre_halt) begin
      check("stop_valid", 32'(bus.inst_valid), 32'(0));
      check("stop_req", 32'(bus.mem_req), 32'(0));
    end else begin
`ifndef FETCH_PREFETCH_EN
      check("take_valid", 32'(bus.inst_valid), 32'(0));
      check("take_req", 32'(bus.mem_req), 32'(1));
`endif
    end
    // Every newly presented instruction follows program order
    if (bus.inst_valid && (!pre_valid || pre_ready)) begin
      check("order_pc", 32'(bus.pc), 32'(exp_pc));
      check("order_inst", 32'(bus.inst), 32'(mem[bus.pc]));
      exp_pc = 8'(bus.pc + 8'd1);
    end
`ifndef FETCH_PREFETCH_EN
    check("req_excl", 32'(bus.mem_req & bus.inst_valid), 32'(0));
`endif
  endtask

  task automatic cycle();
    @(negedge clk);
    pre_rst   = rst;
    pre_req   = bus.mem_req;
    pre_ack   = bus.mem_ack;
    pre_addr  = bus.mem_addr;
    pre_data  = bus.mem_data;
    pre_jmp   = bus.jmp;
    pre_jaddr = bus.jmp_addr;
    pre_halt  = bus.halt;
    pre_ready = bus.inst_ready;
    pre_valid = bus.inst_valid;
    pre_inst  = bus.inst;
    pre_pc    = bus.pc;
    @(posedge clk);
    #1;
    if (pre_rst) model_check();
  endtask

  initial begin
    rst = 1'b0; ack_en = 1'b1; ack_force = 1'b0;
    bus.jmp = 1'b0; bus.jmp_addr = 8'h00; bus.halt = 1'b0; bus.inst_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h05] = 8'hA5; mem[8'h40] = 8'h5A;
    exp_pc = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.mem_req), 32'(0));
    check("rst_valid", 32'(bus.inst_valid), 32'(0));
    check("rst_inst", 32'(bus.inst), 32'(8'h00));
    check("rst_pc", 32'(bus.pc), 32'(8'h00));
    check("rst_addr", 32'(bus.mem_addr), 32'(8'h00));

    // Release, zero-wait memory, consumer always ready
    bus.inst_ready = 1'b1;
    rst = 1'b1;
    cycle();
    check("c2_req", 32'(bus.mem_req), 32'(1));
    check("c2_valid", 32'(bus.inst_valid), 32'(0));
    cycle();
    check("c3_valid", 32'(bus.inst_valid), 32'(1));
    check("c3_inst", 32'(bus.inst), 32'(8'h11));
    check("c3_pc", 32'(bus.pc), 32'(8'h00));
    cycle();
`ifndef FETCH_PREFETCH_EN
    cycle();
`endif
    check("i2_inst", 32'(bus.inst), 32'(8'h22));
    check("i2_pc", 32'(bus.pc), 32'(8'h01));

    // Consumer stalls for five cycles
    bus.inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("stall_valid", 32'(bus.inst_valid), 32'(1));
      check("stall_inst", 32'(bus.inst), 32'(8'h22));
      check("stall_pc", 32'(bus.pc), 32'(8'h01));
`ifndef FETCH_PREFETCH_EN
      check("stall_noreq", 32'(bus.mem_req), 32'(0));
`endif
    end

    // Halt while consuming, then resume at the next address
    bus.halt = 1'b1; bus.inst_ready = 1'b1;
    cycle();
    check("halted_req", 32'(bus.mem_req), 32'(0));
    check("halted_valid", 32'(bus.inst_valid), 32'(0));
    bus.inst_ready = 1'b0;
    repeat (2) cycle();
    check("halted_hold", 32'(bus.mem_req), 32'(0));
    bus.halt = 1'b0;
    cycle();
    check("resume_req1", 32'(bus.mem_req), 32'(1));
    check("resume_addr2", 32'(bus.mem_addr), 32'(8'h02));

    // Jump away from a pending fetch at 0x05; its data must be discarded
    bus.jmp = 1'b1; bus.jmp_addr = 8'h05; ack_en = 1'b0;
    cycle();
    bus.jmp = 1'b0;
    cycle();
    check("pend_addr", 32'(bus.mem_addr), 32'(8'h05));
    bus.jmp = 1'b1; bus.jmp_addr = 8'h40; ack_en = 1'b1;
    cycle();
    check("redir_addr", 32'(bus.mem_addr), 32'(8'h40));
    bus.jmp = 1'b0; bus.inst_ready = 1'b1;
    cycle();
    check("redir_inst", 32'(bus.inst), 32'(8'h5A));
    check("redir_pc", 32'(bus.pc), 32'(8'h40));

    // Fetch at the top of the address space wraps to zero
    bus.jmp = 1'b1; bus.jmp_addr = 8'hFF; bus.inst_ready = 1'b0; ack_en = 1'b0;
    cycle();
    bus.jmp = 1'b0; ack_en = 1'b1;
    cycle();
    check("wrap_pc", 32'(bus.pc), 32'(8'hFF));
    check("wrap_addr", 32'(bus.mem_addr), 32'(8'h00));

    // Reset in the middle of a pending fetch, then a stray late ack
    bus.inst_ready = 1'b1; ack_en = 1'b0;
    cycle();
    check("pre_rst_req", 32'(bus.mem_req), 32'(1));
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(bus.mem_req), 32'(0));
    check("arst_addr", 32'(bus.mem_addr), 32'(8'h00));
    check("arst_valid", 32'(bus.inst_valid), 32'(0));
    check("arst_pc", 32'(bus.pc), 32'(8'h00));
    check("arst_inst", 32'(bus.inst), 32'(8'h00));
    @(posedge clk);
    #1;
    rst = 1'b1; ack_force = 1'b1; exp_pc = 8'h00;
    cycle();
    check("late_valid", 32'(bus.inst_valid), 32'(0));
    check("late_inst", 32'(bus.inst), 32'(8'h00));
    ack_force = 1'b0; ack_en = 1'b1;

`ifdef FETCH_PREFETCH_EN
    // Zero-wait memory with a ready consumer streams one byte per cycle
    cycle();
    for (int k = 0; k < 4; k++) begin
      check("pf_valid", 32'(bus.inst_valid), 32'(1));
      check("pf_pc", 32'(bus.pc), 32'(k));
      cycle();
    end
`endif

    // Random traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      ack_en         = ($urandom_range(0, 9) < 7);
      bus.inst_ready = ($urandom_range(0, 9) < 6);
      bus.jmp        = ($urandom_range(0, 19) == 0);
      bus.jmp_addr   = 8'($urandom);
      if ($urandom_range(0, 15) == 0) bus.halt = ~bus.halt;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
